awe_weight_loader: RTL and testbench

Upstream feeder for `awe_weight_distributor`. It accepts a 64-bit word stream from the memory/DMA side with valid/ready handshaking and buffers it in a small FIFO. It decodes the leading header word into a one-cycle `config_valid`/`config_packet` pulse, then unpacks each payload word into two weight-pair beats on `write_weights_valid`/`weight_input`. The beat count exactly matches the distributor's two-pass table fill.

---
 rtl/awe_pkg.sv | 39 +++
 rtl/awe_sync_fifo.sv | 77 +++++++
 rtl/awe_weight_loader.sv | 204 ++++++++++++++++++++
 tb/tb_awe_weight_loader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/awe_pkg.sv
// awe_pkg: constants and types shared by the weight loader and the weight
// distributor: weight/packet widths, header field layout, loader FSM encoding.
package awe_pkg;

    localparam int C_WEIGHT_WIDTH = 16;
    localparam int C_PACKET_WIDTH = 32;

    // Header word layout: K = [3:0], S = [7:4], M = [15:8]; bits above 15 are ignored.
    localparam int HDR_K_LSB  = 0;
    localparam int HDR_K_BITS = 4;
    localparam int HDR_S_LSB  = 4;
    localparam int HDR_S_BITS = 4;
    localparam int HDR_M_LSB  = 8;
    localparam int HDR_M_BITS = 8;

    // Payload word counts reach 16*16 = 256, so 9 bits are needed.
    localparam int WCNT_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CFG    = 3'd1,
        ST_GAP    = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } awe_state_e;

    // Payload length in words: (K+1)*(S+1), evaluated in 9-bit unsigned.
    function automatic logic [WCNT_BITS-1:0] payload_words(
        input logic [HDR_K_BITS-1:0] k,
        input logic [HDR_S_BITS-1:0] s
    );
        logic [WCNT_BITS-1:0] kp;
        logic [WCNT_BITS-1:0] sp;
        kp = WCNT_BITS'(k) + WCNT_BITS'(1);
        sp = WCNT_BITS'(s) + WCNT_BITS'(1);
        return kp * sp;
    endfunction

endpackage

// File: rtl/awe_sync_fifo.sv
// awe_sync_fifo: single-clock FIFO with show-ahead read data and registered
// full/empty flags. Writes into a full FIFO and reads from an empty FIFO are
// ignored. A word written in cycle T is readable in cycle T+1.
module awe_sync_fifo #(
    parameter int C_WIDTH = 64,
    parameter int C_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [C_WIDTH-1:0] wr_data,
    input  logic               rd_en,
    output logic [C_WIDTH-1:0] rd_data,
    output logic               full,
    output logic               empty
);

    localparam int            AW        = $clog2(C_DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(C_DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [C_WIDTH-1:0] mem [C_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count_q;
    logic [AW:0]        count_d;
    logic               full_q;
    logic               empty_q;
    logic               push;
    logic               pop;

    assign push    = wr_en & ~full_q;
    assign pop     = rd_en & ~empty_q;
    assign rd_data = mem[rd_ptr];
    assign full    = full_q;
    assign empty   = empty_q;

    // Occupancy after this cycle's push/pop; feeds the registered flags.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and flags; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_CNT);
            empty_q <= (count_d == '0);
        end
    end

endmodule

// File: rtl/awe_weight_loader.sv
// awe_weight_loader: buffers a 64-bit word stream, decodes the header word into
// a config_valid/config_packet strobe, then splits each payload word into two
// weight-pair beats (low half first) for awe_weight_distributor.
// Optional build macro AWE_LOADER_LEN_CHECK_EN: checks s_last against the word
// counter and raises a sticky err on a length mismatch. Without it err is 0.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | wait for a header word; pop it, latch K/S/M and word count
// CFG     | config_valid strobe for one cycle
// GAP     | C_CFG_GAP idle cycles before the first beat
// STREAM  | pop a word, emit low half, then high half; bubble if empty
// DONE    | done strobe for one cycle, then back to IDLE
module awe_weight_loader #(
    parameter int C_WEIGHT_WIDTH = awe_pkg::C_WEIGHT_WIDTH,
    parameter int C_PACKET_WIDTH = awe_pkg::C_PACKET_WIDTH,
    parameter int C_IN_WIDTH     = 4*C_WEIGHT_WIDTH,
    parameter int C_FIFO_DEPTH   = 16,
    parameter int C_CFG_GAP      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [C_IN_WIDTH-1:0]       s_data,
    input  logic                        s_last,
    output logic                        config_valid,
    output logic [C_PACKET_WIDTH-1:0]   config_packet,
    output logic                        write_weights_valid,
    output logic [2*C_WEIGHT_WIDTH-1:0] weight_input,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    import awe_pkg::*;

    localparam int         PAIR_W   = 2*C_WEIGHT_WIDTH;
    localparam logic [3:0] GAP_LOAD = 4'(C_CFG_GAP - 1);

`ifdef AWE_LOADER_LEN_CHECK_EN
    localparam int FIFO_W = C_IN_WIDTH + 1;
`else
    localparam int FIFO_W = C_IN_WIDTH;
`endif

    logic [FIFO_W-1:0]     fifo_wdata;
    logic [FIFO_W-1:0]     fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_rd;
    logic [C_IN_WIDTH-1:0] rd_word;

    awe_state_e            state_q;
    awe_state_e            state_d;
    logic [HDR_K_BITS-1:0] k_q;
    logic [HDR_S_BITS-1:0] s_q;
    logic [HDR_M_BITS-1:0] m_q;
    logic [WCNT_BITS-1:0]  words_q;
    logic [3:0]            gap_q;
    logic                  half_q;
    logic [PAIR_W-1:0]     hi_q;

`ifdef AWE_LOADER_LEN_CHECK_EN
    logic rd_last;
    assign fifo_wdata = {s_last, s_data};
    assign rd_word    = fifo_rdata[C_IN_WIDTH-1:0];
    assign rd_last    = fifo_rdata[C_IN_WIDTH];
`else
    logic unused_last;
    assign unused_last = s_last;
    assign fifo_wdata  = s_data;
    assign rd_word     = fifo_rdata;
`endif

    assign s_ready       = ~fifo_full;
    assign busy          = (state_q != ST_IDLE);
    assign config_packet = C_PACKET_WIDTH'({m_q, s_q, k_q});

    awe_sync_fifo #(
        .C_WIDTH (FIFO_W),
        .C_DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s_valid),
        .wr_data (fifo_wdata),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!fifo_empty) state_d = ST_CFG;
            ST_CFG:    state_d = ST_GAP;
            ST_GAP:    if (gap_q == 4'd0) state_d = ST_STREAM;
            ST_STREAM: if (half_q && (words_q == '0)) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output logic: strobes, beat data and FIFO pop request.
    always_comb begin
        config_valid        = 1'b0;
        write_weights_valid = 1'b0;
        weight_input        = '0;
        done                = 1'b0;
        fifo_rd             = 1'b0;
        case (state_q)
            ST_IDLE: fifo_rd = ~fifo_empty;
            ST_CFG:  config_valid = 1'b1;
            ST_STREAM: begin
                if (half_q) begin
                    write_weights_valid = 1'b1;
                    weight_input        = hi_q;
                end else if (!fifo_empty) begin
                    fifo_rd             = 1'b1;
                    write_weights_valid = 1'b1;
                    weight_input        = rd_word[PAIR_W-1:0];
                end
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Header fields, word down-counter, gap timer and pending high half.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q     <= '0;
            s_q     <= '0;
            m_q     <= '0;
            words_q <= '0;
            gap_q   <= '0;
            half_q  <= 1'b0;
            hi_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fifo_rd) begin
                        k_q     <= rd_word[HDR_K_LSB +: HDR_K_BITS];
                        s_q     <= rd_word[HDR_S_LSB +: HDR_S_BITS];
                        m_q     <= rd_word[HDR_M_LSB +: HDR_M_BITS];
                        words_q <= payload_words(rd_word[HDR_K_LSB +: HDR_K_BITS],
                                                 rd_word[HDR_S_LSB +: HDR_S_BITS]);
                        half_q  <= 1'b0;
                    end
                end
                ST_CFG: gap_q <= GAP_LOAD;
                ST_GAP: begin
                    if (gap_q != 4'd0) begin
                        gap_q <= gap_q - 4'd1;
                    end
                end
                ST_STREAM: begin
                    if (half_q) begin
                        half_q <= 1'b0;
                    end else if (fifo_rd) begin
                        hi_q    <= rd_word[2*PAIR_W-1:PAIR_W];
                        half_q  <= 1'b1;
                        words_q <= words_q - WCNT_BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AWE_LOADER_LEN_CHECK_EN
    logic err_q;

    // Sticky length error: s_last must sit on the final payload word and nowhere else.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (fifo_rd) begin
            if ((state_q == ST_IDLE) && rd_last) begin
                err_q <= 1'b1;
            end else if ((state_q == ST_STREAM) && (rd_last != (words_q == WCNT_BITS'(1)))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_awe_weight_loader.sv
// tb_awe_weight_loader: directed transfers; expected config/beat/done events are
// queued when stimulus is issued and a negedge monitor checks DUT output order.
`timescale 1ns/1ps
module tb_awe_weight_loader;

    localparam int CW    = 16;
    localparam int PW    = 32;
    localparam int IW    = 64;
    localparam int DEPTH = 16;
    localparam int GAP   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [IW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          config_valid;
    logic [PW-1:0] config_packet;
    logic          write_weights_valid;
    logic [2*CW-1:0] weight_input;
    logic          busy;
    logic          done;
    logic          err;

    awe_weight_loader #(
        .C_WEIGHT_WIDTH (CW),
        .C_PACKET_WIDTH (PW),
        .C_IN_WIDTH     (IW),
        .C_FIFO_DEPTH   (DEPTH),
        .C_CFG_GAP      (GAP)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_valid             (s_valid),
        .s_ready             (s_ready),
        .s_data              (s_data),
        .s_last              (s_last),
        .config_valid        (config_valid),
        .config_packet       (config_packet),
        .write_weights_valid (write_weights_valid),
        .weight_input        (weight_input),
        .busy                (busy),
        .done                (done),
        .err                 (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0 config, 1 beat, 2 done
        logic [31:0] data;
    } ev_t;

    ev_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  n_beats, first_beat, last_beat, cfg_cyc, done_cyc;
    bit  done_seen;
    bit  saw_full;

`ifdef AWE_LOADER_LEN_CHECK_EN
    localparam logic EXP_LEN_ERR = 1'b1;
`else
    localparam logic EXP_LEN_ERR = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [31:0] data, input string name);
        ev_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: unexpected output %0h with nothing expected (cycle %0d)", name, data, cyc);
        end else begin
            e = sb.pop_front();
            chk(name, {32'(kind), data}, {32'(e.kind), e.data});
        end
    endtask

    // Monitor: every DUT strobe is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (!s_ready) saw_full = 1'b1;
            if (config_valid) begin
                cfg_cyc = cyc;
                expect_ev(0, config_packet, "config");
            end
            if (write_weights_valid) begin
                if (n_beats == 0) first_beat = cyc;
                last_beat = cyc;
                n_beats++;
                expect_ev(1, weight_input, "beat");
            end
            if (done) begin
                done_cyc  = cyc;
                done_seen = 1'b1;
                expect_ev(2, 32'h0, "done");
            end
        end
    end

    function automatic logic [63:0] word_of(input int i);
        return {32'h5A00_0000 + 32'(2*i+1), 32'hA500_0000 + 32'(2*i)};
    endfunction

    task automatic clear_stats();
        n_beats = 0; first_beat = -1; last_beat = -1;
        cfg_cyc = -1; done_cyc = -1; done_seen = 1'b0; saw_full = 1'b0;
    endtask

    task automatic queue_expect(input logic [15:0] hdr, input int nwords);
        logic [63:0] w;
        sb.push_back('{kind: 0, data: {16'h0, hdr}});
        for (int i = 1; i <= nwords; i++) begin
            w = word_of(i);
            sb.push_back('{kind: 1, data: w[31:0]});
            sb.push_back('{kind: 1, data: w[63:32]});
        end
        sb.push_back('{kind: 2, data: 32'h0});
    endtask

    // Offers one word and returns the cycle number of the accepting edge.
    task automatic push(input logic [63:0] d, input logic l, output int acc);
        int n = 0;
        bit ok = 1'b0;
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!ok && n < 2000) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL push_timeout: s_ready stayed 0, expected 1 within 2000 cycles");
            acc = -1;
        end else begin
            @(posedge clk); #1;
            acc = cyc;
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic push_words(input int from, input int to, input int last_at);
        int acc;
        for (int i = from; i <= to; i++) push(word_of(i), (i == last_at), acc);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done_seen && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("done_seen", 64'(done_seen), 64'd1);
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while (n_beats < target && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n_beats < target) chk("beat_wait", 64'(n_beats), 64'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"},       64'(s_ready), 64'd1);
        chk({tag, "_config_valid"},  64'(config_valid), 64'd0);
        chk({tag, "_config_packet"}, 64'(config_packet), 64'd0);
        chk({tag, "_wwv"},           64'(write_weights_valid), 64'd0);
        chk({tag, "_weight_input"},  64'(weight_input), 64'd0);
        chk({tag, "_busy"},          64'(busy), 64'd0);
        chk({tag, "_done"},          64'(done), 64'd0);
        chk({tag, "_err"},           64'(err), 64'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hdr_acc;

        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic transfer, FIFO fed back-to-back: K=1,S=2,M=8 -> 6 words, 12 beats.
        clear_stats();
        queue_expect(16'h0821, 6);
        push({48'hDEAD_BEEF_CAFE, 16'h0821}, 1'b0, hdr_acc);
        push_words(1, 6, 6);
        wait_done(200);
        chk("t1_cfg_latency",  64'(cfg_cyc - hdr_acc), 64'd1);
        chk("t1_first_beat",   64'(first_beat - cfg_cyc), 64'd3);
        chk("t1_beat_span",    64'(last_beat - first_beat), 64'd11);
        chk("t1_beat_count",   64'(n_beats), 64'd12);
        chk("t1_done_latency", 64'(done_cyc - last_beat), 64'd1);
        chk("t1_busy_after",   64'(busy), 64'd0);
        chk("t1_err",          64'(err), 64'd0);

        // Source stalls after word 3 until it drains, then 4 more cycles: 5 bubbles.
        clear_stats();
        queue_expect(16'h1321, 6);
        push({48'h0, 16'h1321}, 1'b0, hdr_acc);
        push_words(1, 3, 6);
        wait_beats(6);
        repeat (4) @(posedge clk);
        #1;
        push_words(4, 6, 6);
        wait_done(200);
        chk("t3_beat_count", 64'(n_beats), 64'd12);
        chk("t3_bubbles",    64'((last_beat - first_beat + 1) - n_beats), 64'd5);
        chk("t3_err",        64'(err), 64'd0);

        // Largest transfer: K=15,S=15 -> 256 words, 512 beats, FIFO backpressure.
        clear_stats();
        queue_expect(16'hFFFF, 256);
        push({48'h0, 16'hFFFF}, 1'b0, hdr_acc);
        push_words(1, 256, 256);
        wait_done(1000);
        chk("t4_beat_count",   64'(n_beats), 64'd512);
        chk("t4_beat_span",    64'(last_beat - first_beat), 64'd511);
        chk("t4_done_latency", 64'(done_cyc - last_beat), 64'd1);
        chk("t4_saw_full",     64'(saw_full), 64'd1);

        // s_last on word 4 of 6: all beats still produced; err only with length check.
        clear_stats();
        queue_expect(16'h0821, 6);
        push({48'h0, 16'h0821}, 1'b0, hdr_acc);
        push_words(1, 6, 4);
        wait_done(200);
        chk("t5_beat_count", 64'(n_beats), 64'd12);
        chk("t5_err",        64'(err), 64'(EXP_LEN_ERR));

        // Reset asserted during beat 5 aborts the transfer with no done.
        clear_stats();
        queue_expect(16'h0821, 6);
        push({48'h0, 16'h0821}, 1'b0, hdr_acc);
        push_words(1, 6, 6);
        wait_beats(4);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_beats_before_abort", 64'(n_beats), 64'd4);
        chk("t6_no_done",            64'(done_seen), 64'd0);

        // Fresh transfer after the abort: K=0,S=1,M=0x3C -> 2 words.
        clear_stats();
        queue_expect(16'h3C10, 2);
        push({48'h1234_5678_9ABC, 16'h3C10}, 1'b0, hdr_acc);
        push_words(1, 2, 2);
        wait_done(200);
        chk("t6_cfg_latency", 64'(cfg_cyc - hdr_acc), 64'd1);
        chk("t6_beat_count",  64'(n_beats), 64'd4);
        chk("t6_err",         64'(err), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
